sram_track_arbiter: RTL

Two-port arbiter that shares the single-port 8 KiB track-buffer SRAM between the disk-side engine (MFM serializer/deserializer, real-time) and the host-side engine (MCU/SPI bridge, best-effort). It accepts one access per cycle from either requester over a req/ack handshake and drives the SRAM's registered-read, active-low-enable command bus. It tags each read in flight and returns the SRAM read data to the requester that issued it. Disk priority is bounded by an anti-starvation counter for the host.

---
 rtl/sram_track_arbiter_if.sv | 28 ++
 rtl/sram_track_arbiter.sv | 93 +++++++++
 2 files changed

// File: rtl/sram_track_arbiter_if.sv
// Requester and SRAM command/return bus shared between the track-buffer
// arbiter (slave) and its environment: the two engines plus the SRAM (master).
interface sram_track_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          d_req, d_we, d_ack, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          h_req, h_we, h_ack, h_rvalid;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata, h_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;
    logic          sram_rw, sram_en;

    modport master (
        output d_req, d_we, d_addr, d_wdata, h_req, h_we, h_addr, h_wdata, sram_dout,
        input  d_ack, d_rvalid, d_rdata, h_ack, h_rvalid, h_rdata,
        input  sram_addr, sram_din, sram_rw, sram_en
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, h_req, h_we, h_addr, h_wdata, sram_dout,
        output d_ack, d_rvalid, d_rdata, h_ack, h_rvalid, h_rdata,
        output sram_addr, sram_din, sram_rw, sram_en
    );
endinterface

// File: rtl/sram_track_arbiter.sv
// Shares the single-port track-buffer SRAM between the real-time disk engine
// and the best-effort host engine; host is guaranteed service after STARVE_LIMIT losses.
module sram_track_arbiter #(
    parameter int AW           = 13,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    sram_track_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]    starve_q, starve_d;
    logic          d_ack, h_ack, xfer;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          en_q, rw_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    // Tag pipeline: [1] = command stage, [2] = SRAM access stage.
    logic [2:1]    vld_pipe_q;
    logic [2:1]    port_pipe_q;
    logic          d_rvalid_q, h_rvalid_q;
    logic [DW-1:0] d_rdata_q, h_rdata_q;

    always_comb begin
        d_ack = 1'b0;
        h_ack = 1'b0;
        if (!rst) begin
            if (bus.h_req && (!bus.d_req || starve_q == LIMIT)) h_ack = 1'b1;
            else if (bus.d_req)                                  d_ack = 1'b1;
        end
    end

    assign xfer      = d_ack | h_ack;
    assign sel_we    = h_ack ? bus.h_we    : bus.d_we;
    assign sel_addr  = h_ack ? bus.h_addr  : bus.d_addr;
    assign sel_wdata = h_ack ? bus.h_wdata : bus.d_wdata;

    always_comb begin
        starve_d = 4'd0;
        if (bus.h_req && !h_ack)
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= 4'd0;
            en_q        <= 1'b1;
            rw_q        <= 1'b1;
            addr_q      <= '0;
            din_q       <= '0;
            vld_pipe_q  <= '0;
            port_pipe_q <= '0;
            d_rvalid_q  <= 1'b0;
            h_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            h_rdata_q   <= '0;
        end else begin
            starve_q <= starve_d;
            if (xfer) begin
                en_q   <= 1'b0;
                rw_q   <= ~sel_we;
                addr_q <= sel_addr;
                din_q  <= sel_wdata;
            end else begin
                en_q <= 1'b1;
                rw_q <= 1'b1;
            end
            vld_pipe_q  <= {vld_pipe_q[1], xfer & ~sel_we};
            port_pipe_q <= {port_pipe_q[1], h_ack};
            // sram_dout is only sampled for a tagged read, so idle high-Z never lands in rdata.
            d_rvalid_q <= vld_pipe_q[2] & ~port_pipe_q[2];
            h_rvalid_q <= vld_pipe_q[2] &  port_pipe_q[2];
            if (vld_pipe_q[2] && !port_pipe_q[2]) d_rdata_q <= bus.sram_dout;
            if (vld_pipe_q[2] &&  port_pipe_q[2]) h_rdata_q <= bus.sram_dout;
        end
    end

    assign bus.d_ack     = d_ack;
    assign bus.h_ack     = h_ack;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.h_rvalid  = h_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.h_rdata   = h_rdata_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_din  = din_q;
    assign bus.sram_rw   = rw_q;
    assign bus.sram_en   = en_q;
endmodule
